// File: rtl/fixed_softplus_pwq.sv
`default_nettype none
// ============================================================================
// Module   : fixed_softplus_pwq
// Purpose  : N-lane softplus, 4-segment piecewise quadratic, 3-stage stallable
// Revision : 1.0
// ============================================================================
module fixed_softplus_pwq #(
  parameter int DATA_IN_0_PRECISION_0       = 16,
  parameter int DATA_IN_0_PRECISION_1       = 8,
  parameter int DATA_OUT_0_PRECISION_0      = 16,
  parameter int DATA_OUT_0_PRECISION_1      = 8,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 1,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_OUT_0_TENSOR_SIZE_DIM_0 = 1,
  parameter int DATA_OUT_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int COEF_FRAC                   = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0  [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0],
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0],
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
);

  localparam int c_N   = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int c_IW  = DATA_IN_0_PRECISION_0;
  localparam int c_IF  = DATA_IN_0_PRECISION_1;
  localparam int c_OW  = DATA_OUT_0_PRECISION_0;
  localparam int c_OF  = DATA_OUT_0_PRECISION_1;
  // Tensor sizes only exist so the toolflow can pass them through.
  localparam int c_unused_tensor_sz = DATA_IN_0_TENSOR_SIZE_DIM_0 + DATA_IN_0_TENSOR_SIZE_DIM_1
                                    + DATA_OUT_0_TENSOR_SIZE_DIM_0 + DATA_OUT_0_TENSOR_SIZE_DIM_1;

  localparam int c_CW  = COEF_FRAC + 2;
  localparam int c_P1W = c_CW + c_IW;
  localparam int c_TW  = c_CW + c_IW - c_IF + 1;
  localparam int c_PW  = c_TW + c_IW + 1;
  localparam int c_PRW = c_PW + 1;
  localparam int c_S   = COEF_FRAC + c_IF - c_OF;
  localparam int c_SH  = (c_OF >= c_IF) ? (c_OF - c_IF) : (c_IF - c_OF);
  localparam int c_HW  = c_IW + c_SH + 1;
  localparam int c_MW  = (c_PRW > c_HW) ? c_PRW : c_HW;
  localparam int c_YW  = ((c_MW > c_OW) ? c_MW : c_OW) + 1;

  localparam logic [1:0] c_RG_LOW  = 2'd0;
  localparam logic [1:0] c_RG_POLY = 2'd1;
  localparam logic [1:0] c_RG_HIGH = 2'd2;

  // Coefficient codes are authored in Q1.15 and rounded into COEF_FRAC.
  function automatic logic signed [c_CW-1:0] f_coef(input longint code);
    longint v;
    if (COEF_FRAC >= 15) v = code <<< (COEF_FRAC - 15);
    else                 v = (code + (64'sd1 <<< (14 - COEF_FRAC))) >>> (15 - COEF_FRAC);
    return c_CW'(v);
  endfunction

  localparam logic signed [c_CW-1:0] c_A2_S1 = f_coef(779);
  localparam logic signed [c_CW-1:0] c_A1_S1 = f_coef(6383);
  localparam logic signed [c_CW-1:0] c_A0_S1 = f_coef(13710);
  localparam logic signed [c_CW-1:0] c_A2_S2 = f_coef(3175);
  localparam logic signed [c_CW-1:0] c_A1_S2 = f_coef(15464);
  localparam logic signed [c_CW-1:0] c_A0_S2 = f_coef(22558);
  localparam logic signed [c_CW-1:0] c_A2_S3 = f_coef(3175);
  localparam logic signed [c_CW-1:0] c_A1_S3 = f_coef(17303);
  localparam logic signed [c_CW-1:0] c_A0_S3 = f_coef(22558);
  localparam logic signed [c_CW-1:0] c_A2_S4 = f_coef(779);
  localparam logic signed [c_CW-1:0] c_A1_S4 = f_coef(26384);
  localparam logic signed [c_CW-1:0] c_A0_S4 = f_coef(13710);

  localparam logic signed [c_IW-1:0] c_TH_N4 = c_IW'(-(64'sd4 <<< c_IF));
  localparam logic signed [c_IW-1:0] c_TH_N2 = c_IW'(-(64'sd2 <<< c_IF));
  localparam logic signed [c_IW-1:0] c_TH_Z  = '0;
  localparam logic signed [c_IW-1:0] c_TH_P2 = c_IW'(64'sd2 <<< c_IF);
  localparam logic signed [c_IW-1:0] c_TH_P4 = c_IW'(64'sd4 <<< c_IF);

  // Half-LSB of the final scale; collapses to zero when no shift is needed.
  localparam logic signed [c_PRW-1:0] c_RND_P = c_PRW'((64'sd1 <<< c_S) >>> 1);

  localparam logic signed [c_YW-1:0] c_OMAX   = {{(c_YW-c_OW+1){1'b0}}, {(c_OW-1){1'b1}}};
  localparam logic signed [c_YW-1:0] c_OMIN   = ~c_OMAX;
  localparam logic [c_OW-1:0]        c_SAT_HI = {1'b0, {(c_OW-1){1'b1}}};
  localparam logic [c_OW-1:0]        c_SAT_LO = {1'b1, {(c_OW-1){1'b0}}};

  logic w_en;
  logic r_v1, r_v2, r_v3;

  assign w_en             = !r_v3 || data_out_0_ready;
  assign data_in_0_ready  = w_en;
  assign data_out_0_valid = r_v3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_en) begin
      r_v1 <= data_in_0_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  for (genvar gi = 0; gi < c_N; gi++) begin : g_lane
    logic signed [c_IW-1:0]  w_x;
    logic [1:0]              w_rg;
    logic signed [c_CW-1:0]  w_a2, w_a1, w_a0;
    logic signed [c_IW-1:0]  r_x1, r_x2;
    logic [1:0]              r_rg1, r_rg2;
    logic signed [c_CW-1:0]  r_a2, r_a1, r_a0_1, r_a0_2;
    logic signed [c_P1W-1:0] w_p1;
    logic signed [c_TW-1:0]  w_t, r_t;
    logic signed [c_PW-1:0]  w_p;
    logic signed [c_PRW-1:0] w_psum, w_ypoly;
    logic signed [c_HW-1:0]  w_yhigh;
    logic signed [c_YW-1:0]  w_yfull;
    logic [c_OW-1:0]         w_ysat, r_y;

    assign w_x = data_in_0[gi];

    always_comb begin
      w_rg = c_RG_POLY;
      w_a2 = c_A2_S4;
      w_a1 = c_A1_S4;
      w_a0 = c_A0_S4;
      if (w_x < c_TH_N4) begin
        w_rg = c_RG_LOW;
      end else if (w_x >= c_TH_P4) begin
        w_rg = c_RG_HIGH;
      end else if (w_x < c_TH_N2) begin
        w_a2 = c_A2_S1; w_a1 = c_A1_S1; w_a0 = c_A0_S1;
      end else if (w_x < c_TH_Z) begin
        w_a2 = c_A2_S2; w_a1 = c_A1_S2; w_a0 = c_A0_S2;
      end else if (w_x < c_TH_P2) begin
        w_a2 = c_A2_S3; w_a1 = c_A1_S3; w_a0 = c_A0_S3;
      end
    end

    // Horner form: t = a2*x + a1, then p = t*x + a0, all at coefficient scale.
    assign w_p1    = c_P1W'(r_a2) * c_P1W'(r_x1);
    assign w_t     = c_TW'(w_p1 >>> c_IF) + c_TW'(r_a1);
    assign w_p     = c_PW'(r_t) * c_PW'(r_x2) + (c_PW'(r_a0_2) <<< c_IF);
    assign w_psum  = c_PRW'(w_p) + c_RND_P;
    assign w_ypoly = w_psum >>> c_S;

    if (c_OF >= c_IF) begin : g_hi_left
      assign w_yhigh = c_HW'(r_x2) <<< (c_OF - c_IF);
    end else begin : g_hi_right
      localparam logic signed [c_HW-1:0] c_RND_H = c_HW'((64'sd1 <<< c_SH) >>> 1);
      assign w_yhigh = (c_HW'(r_x2) + c_RND_H) >>> (c_IF - c_OF);
    end

    always_comb begin
      w_yfull = '0;
      if (r_rg2 == c_RG_POLY)      w_yfull = c_YW'(w_ypoly);
      else if (r_rg2 == c_RG_HIGH) w_yfull = c_YW'(w_yhigh);
    end

    always_comb begin
      if (w_yfull > c_OMAX)      w_ysat = c_SAT_HI;
      else if (w_yfull < c_OMIN) w_ysat = c_SAT_LO;
      else                       w_ysat = w_yfull[c_OW-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_x1   <= '0;
        r_rg1  <= c_RG_LOW;
        r_a2   <= '0;
        r_a1   <= '0;
        r_a0_1 <= '0;
        r_x2   <= '0;
        r_rg2  <= c_RG_LOW;
        r_t    <= '0;
        r_a0_2 <= '0;
        r_y    <= '0;
      end else if (w_en) begin
        r_x1   <= w_x;
        r_rg1  <= w_rg;
        r_a2   <= w_a2;
        r_a1   <= w_a1;
        r_a0_1 <= w_a0;
        r_x2   <= r_x1;
        r_rg2  <= r_rg1;
        r_t    <= w_t;
        r_a0_2 <= r_a0_1;
        r_y    <= w_ysat;
      end
    end

    assign data_out_0[gi] = r_y;
  end

endmodule
`default_nettype wire

// File: tb/tb_fixed_softplus_pwq.sv
`default_nettype none
// Testbench for fixed_softplus_pwq: 4-lane default instance plus a 12-bit output
// instance, checked against a plain-arithmetic softplus approximation model.
module tb_fixed_softplus_pwq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] din [3:0];
  logic        din_valid, din_ready;
  logic [15:0] dout [3:0];
  logic        dout_valid, dout_ready;
  logic [63:0] dout_p;
  assign dout_p = {dout[3], dout[2], dout[1], dout[0]};

  logic [15:0] sdin [0:0];
  logic        s_valid, s_in_ready;
  logic [11:0] sdout [0:0];
  logic        s_out_valid, s_ready;

  int total = 0;
  int bad   = 0;

  fixed_softplus_pwq #(.DATA_IN_0_PARALLELISM_DIM_0(4)) u_dut (
    .clk(clk), .rst(rst),
    .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(din_ready),
    .data_out_0(dout), .data_out_0_valid(dout_valid), .data_out_0_ready(dout_ready)
  );

  fixed_softplus_pwq #(.DATA_OUT_0_PRECISION_0(12)) u_sat (
    .clk(clk), .rst(rst),
    .data_in_0(sdin), .data_in_0_valid(s_valid), .data_in_0_ready(s_in_ready),
    .data_out_0(sdout), .data_out_0_valid(s_out_valid), .data_out_0_ready(s_ready)
  );

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // Real-valued segments evaluated with exact integers: x has 8 frac bits,
  // coefficients 15, result rounded half-up to 8 frac bits.
  function automatic longint model(input logic signed [15:0] xs, input int ow);
    longint x, a2, a1, a0, t, p, y, lim;
    x = xs;
    a2 = 779; a1 = 26384; a0 = 13710;
    if (x < -4 * 256)      y = 0;
    else if (x >= 4 * 256) y = x;
    else begin
      if (x < -2 * 256)   begin a2 = 779;  a1 = 6383;  a0 = 13710; end
      else if (x < 0)     begin a2 = 3175; a1 = 15464; a0 = 22558; end
      else if (x < 512)   begin a2 = 3175; a1 = 17303; a0 = 22558; end
      t = fdiv(a2 * x, 256) + a1;
      p = t * x + a0 * 256;
      y = fdiv(p + 16384, 32768);
    end
    lim = longint'(1) << (ow - 1);
    if (y > lim - 1) y = lim - 1;
    if (y < -lim)    y = -lim;
    return y;
  endfunction

  function automatic logic [63:0] exp_beat(input logic [63:0] b);
    logic [63:0] r;
    for (int l = 0; l < 4; l++) r[16*l +: 16] = 16'(model(b[16*l +: 16], 16));
    return r;
  endfunction

  function automatic logic [15:0] rand_x();
    if ($urandom_range(0, 1) == 1) return 16'($urandom_range(0, 65535));
    return 16'($urandom_range(0, 2200)) - 16'd1100;
  endfunction

  task automatic set_in(input logic [63:0] b);
    for (int l = 0; l < 4; l++) din[l] = b[16*l +: 16];
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    dout_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
    total++; if (dout_p !== 64'd0) begin bad++; $display("FAIL reset_data: got %h want 0", dout_p); end
    total++; if (s_out_valid !== 1'b0) begin bad++; $display("FAIL reset_sat_valid: got %b want 0", s_out_valid); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", din_ready); end
  endtask

  task automatic test_vectors();
    logic [63:0] vin [3];
    logic [63:0] vex [3];
    vin[0] = 64'h0200_FF00_0100_0000; vex[0] = 64'h0220_0050_0150_00B0;
    vin[1] = 64'h0500_0400_FC00_FB00; vex[1] = 64'h0500_0400_0005_0000;
    vin[2] = 64'h0500_FB00_0100_0000; vex[2] = 64'h0500_0000_0150_00B0;
    idle(4);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      set_in(vin[b]);
      din_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      din_valid = 1'b0;
      total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL vec%0d_lat1: got %b want 0", b, dout_valid); end
      @(negedge clk);
      total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL vec%0d_lat2: got %b want 0", b, dout_valid); end
      @(negedge clk);
      total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL vec%0d_lat3: got %b want 1", b, dout_valid); end
      for (int l = 0; l < 4; l++) begin
        total++;
        if (dout[l] !== vex[b][16*l +: 16]) begin
          bad++; $display("FAIL vec%0d_lane%0d: got %h want %h", b, l, dout[l], vex[b][16*l +: 16]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q[$];
    logic [63:0] bt [8];
    logic [63:0] e;
    logic        want_v;
    bt[0] = 64'hFE00_FDFF_FC00_FBFF;
    bt[1] = 64'h0200_01FF_0000_FFFF;
    bt[2] = 64'h8000_7FFF_0400_03FF;
    for (int i = 3; i < 8; i++) bt[i] = {rand_x(), rand_x(), rand_x(), rand_x()};
    idle(4);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      want_v = (c >= 3 && c < 11);
      total++; if (dout_valid !== want_v) begin bad++; $display("FAIL b2b_valid c%0d: got %b want %b", c, dout_valid, want_v); end
      total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready c%0d: got %b want 1", c, din_ready); end
      if (dout_valid === 1'b1) begin
        e = (q.size() > 0) ? q.pop_front() : 64'hx;
        total++; if (dout_p !== e) begin bad++; $display("FAIL b2b_data c%0d: got %h want %h", c, dout_p, e); end
      end
      if (c < 8) begin
        set_in(bt[c]);
        din_valid = 1'b1;
        q.push_back(exp_beat(bt[c]));
      end else begin
        din_valid = 1'b0;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] sx [6];
    logic [11:0] se [6];
    sx[0] = 16'h0A00; se[0] = 12'h7FF;
    sx[1] = 16'h0800; se[1] = 12'h7FF;
    sx[2] = 16'h07FF; se[2] = 12'h7FF;
    sx[3] = 16'h8000; se[3] = 12'h000;
    sx[4] = 16'h7FFF; se[4] = 12'h7FF;
    sx[5] = 16'h0100; se[5] = 12'h150;
    s_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sdin[0] = sx[i];
      s_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (s_out_valid !== 1'b1) begin bad++; $display("FAIL sat%0d_valid: got %b want 1", i, s_out_valid); end
      total++; if (sdout[0] !== se[i]) begin bad++; $display("FAIL sat%0d_data: got %h want %h", i, sdout[0], se[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] q[$];
    logic [63:0] beat, e, held_val;
    logic held, acc_in, acc_out, acc_prev;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; held = 1'b0; acc_prev = 1'b0; beat = '0;
    idle(4);
    while (got < 16 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        total++;
        if (dout_valid !== 1'b1 || dout_p !== held_val) begin
          bad++; $display("FAIL bp_hold: got v=%b %h want v=1 %h", dout_valid, dout_p, held_val);
        end
      end
      dout_ready = ($urandom_range(0, 1) == 1);
      if (acc_prev) din_valid = 1'b0;
      if (!din_valid && sent < 16 && $urandom_range(0, 3) != 0) begin
        beat = {rand_x(), rand_x(), rand_x(), rand_x()};
        set_in(beat);
        din_valid = 1'b1;
        sent++;
      end
      #1;
      acc_in  = din_valid && din_ready;
      acc_out = dout_valid && dout_ready;
      if (acc_out) begin
        e = (q.size() > 0) ? q.pop_front() : 64'hx;
        got++;
        total++; if (dout_p !== e) begin bad++; $display("FAIL bp_data beat%0d: got %h want %h", got, dout_p, e); end
      end
      held = dout_valid && !dout_ready;
      held_val = dout_p;
      if (acc_in) q.push_back(exp_beat(beat));
      acc_prev = acc_in;
      @(posedge clk);
    end
    total++; if (got != 16) begin bad++; $display("FAIL bp_count: got %0d want 16", got); end
    idle(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL bp_extra: got %b want 0", dout_valid); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [63:0] nb;
    int k;
    idle(4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_in({rand_x(), rand_x(), rand_x(), rand_x()});
      din_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    din_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", dout_valid); end
    total++; if (dout_p !== 64'd0) begin bad++; $display("FAIL mid_rst_data: got %h want 0", dout_p); end
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b want 1", din_ready); end
    nb = 64'h0100_0400_FC00_FF00;
    set_in(nb);
    din_valid = 1'b1;
    @(posedge clk);
    k = 0;
    while (k < 10) begin
      @(negedge clk);
      din_valid = 1'b0;
      k++;
      if (dout_valid === 1'b1) break;
    end
    total++; if (k != 3) begin bad++; $display("FAIL mid_first_latency: got %0d want 3", k); end
    total++; if (dout_p !== exp_beat(nb)) begin bad++; $display("FAIL mid_first_data: got %h want %h", dout_p, exp_beat(nb)); end
  endtask

  initial begin
    rst = 1'b1;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    s_valid = 1'b0;
    s_ready = 1'b1;
    for (int l = 0; l < 4; l++) din[l] = '0;
    sdin[0] = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fixed_softplus_pwq.md
# fixed_softplus_pwq

Parametrised, fully handshaked softplus activation for the activations library. It evaluates a 4-segment piecewise-quadratic approximation over [-4, 4), outputs 0 below -4 and outputs x at or above 4. Parallel lanes are evaluated in a 3-stage pipeline with a global stall. The block sits between streaming linear/conv outputs and downstream consumers. It replaces the single-cycle, unstalled softplus with explicit fixed-point scaling, rounding and saturation.

## Interface
- DATA_IN_0_PRECISION_0, 16: input word width (signed).
- DATA_IN_0_PRECISION_1, 8: input fractional bits; DATA_IN_0_PRECISION_0 - DATA_IN_0_PRECISION_1 >= 4.
- DATA_OUT_0_PRECISION_0, 16: output word width (signed).
- DATA_OUT_0_PRECISION_1, 8: output fractional bits; must be <= COEF_FRAC + input frac.
- DATA_IN_0_PARALLELISM_DIM_0 / _DIM_1, 1 / 1: lanes per beat, N = DIM_0*DIM_1. Output parallelism is equal.
- DATA_IN_0_TENSOR_SIZE_DIM_0/1, DATA_OUT_0_TENSOR_SIZE_DIM_0/1: accepted for toolflow compatibility; unused.
- COEF_FRAC, 15: fractional bits of the coefficient ROM (Q1.COEF_FRAC).
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- data_in_0, in, N x DATA_IN_0_PRECISION_0: input lanes.
- data_in_0_valid, in, 1: input beat valid.
- data_in_0_ready, out, 1: input beat accepted when high with valid.
- data_out_0, out, N x DATA_OUT_0_PRECISION_0: output lanes.
- data_out_0_valid, out, 1: output beat valid.
- data_out_0_ready, in, 1: downstream accepts.

## Operation
- Coefficients (a2, a1, a0), Q1.15 integer codes:
  - seg1 [-4,-2): 779, 6383, 13710.
  - seg2 [-2,0): 3175, 15464, 22558.
  - seg3 [0,2): 3175, 17303, 22558.
  - seg4 [2,4): 779, 26384, 13710.
- When COEF_FRAC != 15, the codes are rescaled at elaboration.
- Thresholds are compared against k << in_frac, with k in {-4, -2, 0, 2, 4}. Lower bounds are inclusive; upper bounds are exclusive.
- Stage 1 (S1) registers x, selects the segment and registers the coefficients plus a region flag (LOW, POLY, HIGH).
- Stage 2 (S2) computes t = ((a2*x) >>> in_frac) + a1. Use full-precision signed products; t is in coefficient scale.
- Stage 3 (S3) computes p = t*x + (a0 << in_frac), in scale COEF_FRAC + in_frac.
  - s = COEF_FRAC + in_frac - out_frac.
  - y = (p + 2^(s-1)) >>> s (round half up); when s = 0, y = p.
- Region outputs:
  - LOW: y = 0.
  - HIGH: y = x rescaled to out_frac (shift left, or round-half-up shift right).
- Saturation: y is clamped to the signed range of DATA_OUT_0_PRECISION_0, giving 2^(W-1)-1 or -2^(W-1).
- Intermediates must be wide enough that no internal overflow occurs for any input.
- All lanes share one valid bit per stage and advance together.

## Timing
- Global enable: en = !v3 || data_out_0_ready.
  - data_in_0_ready = en (combinational).
  - When en is high, v1 <= data_in_0_valid, v2 <= v1 and v3 <= v2, and the data registers follow.
  - When en is low, all stage registers hold.
- Latency: 3 cycles from accepted input to data_out_0_valid. Throughput is 1 beat/cycle while data_out_0_ready stays high.
- data_out_0_valid = v3; data_out_0 = S3 register.
  - While valid and not ready, the output is held stable, with no change until the handshake.
- Bubbles (valid low) propagate as bubbles. Empty stages never produce valid.
- Reset: v1, v2 and v3 become 0 and data_out_0 becomes 0; data_out_0_valid = 0.
  - data_in_0_ready is 1 in the cycle after reset because v3 = 0.
  - A reset mid-stream discards all in-flight beats, with no partial output.
- Simultaneous accept at input and output under full occupancy sustains full throughput, with no bubble inserted.

## Test plan
- Defaults, one lane:
  - x = 0x0000 -> 0x00B0.
  - x = 0x0100 (1.0) -> 0x0150.
  - x = 0xFF00 (-1.0) -> 0x0050.
  - x = 0x0200 (2.0) -> 0x0220.
  - Each output appears exactly 3 cycles after acceptance.
- Regions:
  - x = 0xFB00 (-5.0) -> 0x0000.
  - x = 0xFC00 (-4.0) -> seg1 result.
  - x = 0x0400 (4.0) -> 0x0400.
  - x = 0x0500 -> 0x0500.
- Saturation: DATA_OUT_0_PRECISION_0 = 12, x = 0x0A00 (10.0) -> 0x7FF.
- Backpressure:
  - Stream 16 random beats with data_out_0_ready toggled pseudo-randomly; outputs must match the reference model in order, with no loss or duplication.
  - data_out_0 must be stable while valid is high and ready is low.
- Parallelism: DIM_0 = 4, lanes {0x0000, 0x0100, 0xFB00, 0x0500} -> {0x00B0, 0x0150, 0x0000, 0x0500} in one beat.
- Reset: assert rst with 3 beats in flight.
  - Next cycle: data_out_0_valid = 0 and data_out_0 = 0.
  - After release: the first output is the first beat accepted after reset.
